real_mul_arbiter: RTL and testbench
===================================

REAL_MUL_ARBITER -- requirements
Module: real_mul_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of requesters; WIDTH, default 18, signed operand/result width; A_EXP, B_EXP, OUT_EXP, default -12 each, fixed-point exponents (value = code * 2^EXP).
REQ-002 Ports SHALL be, in order: clk  in  1  sole clock.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 req_valid  in  N_REQ  per-requester operand valid.
REQ-005 req_ready  out  N_REQ  per-requester accept (one-hot or zero).
REQ-006 req_a, req_b  in  N_REQ x WIDTH  signed operands per requester.
REQ-007 resp_valid  out  1  result valid.
REQ-008 resp_ready  in  1  downstream accept.
REQ-009 resp_id  out  clog2(N_REQ)  index of the requester that owns the result.
REQ-010 resp_data  out  WIDTH  signed product in OUT_EXP format.
REQ-011 resp_sat  out  1  result was saturated.

Function
REQ-012 One shared signed WIDTH x WIDTH multiplier SHALL serve all requesters; a transfer occurs on a cycle where req_valid[i] && req_ready[i].
REQ-013 Pipeline enable: en = !resp_valid || resp_ready; when en=0, all stages SHALL hold and req_ready SHALL be all-zero.
REQ-014 Arbitration SHALL be round-robin: the search starts at last_grant+1 mod N_REQ; the first requester with req_valid set is granted; req_ready = grant when en=1.
REQ-015 last_grant SHALL update only on an accepted transfer; it is unchanged on idle or stalled cycles.
REQ-016 req_ready SHALL depend combinationally on req_valid and en; a requester holding valid without acceptance SHALL keep its priority position.
REQ-017 Stage 1 SHALL register the operands, the id and a valid bit; stage 2 SHALL compute the full 2*WIDTH product, arithmetic-right-shift it by SHIFT = OUT_EXP-A_EXP-B_EXP (floor rounding), saturate it and register it into resp_*.
REQ-018 Latency SHALL be 2 cycles from the accept edge to resp_valid; sustained throughput SHALL be 1 result per cycle with resp_ready=1.
REQ-019 Saturation: a shifted value > 2^(WIDTH-1)-1 SHALL give 2^(WIDTH-1)-1, and a value < -2^(WIDTH-1) SHALL give -2^(WIDTH-1); resp_sat=1 exactly for these results.
REQ-020 SHIFT < 0 or N_REQ < 2 SHALL be an elaboration-time fatal error.
REQ-021 resp_data, resp_id and resp_sat SHALL stay stable while resp_valid=1 and resp_ready=0.
REQ-022 Results SHALL emerge in acceptance order; no result may be dropped or duplicated.

Reset
REQ-023 On rst=1 at a clk edge: stage valid bits, resp_valid and resp_sat SHALL be 0; resp_data and resp_id SHALL be 0; last_grant SHALL be N_REQ-1, so requester 0 has first priority.
REQ-024 req_ready SHALL be all-zero while rst=1; in-flight operations SHALL be discarded without producing a response.

Structure
REQ-025 Package real_mul_arbiter_pkg SHALL hold the saturation limit helpers and the SHIFT computation; N_REQ and WIDTH SHALL remain module parameters.
REQ-026 The round-robin grant logic SHALL be a sub-module rr_arbiter (inputs: req, last_grant, en; outputs: one-hot grant, grant index).

Verification (WIDTH=18, all exponents -12 unless stated, so 1.0 = 4096)
REQ-027 Requester 0: a=6144 (1.5), b=8192 (2.0), resp_ready=1 -> two cycles after accept, resp_valid=1, resp_data=12288, resp_id=0, resp_sat=0.
REQ-028 a=-6144, b=8192 -> resp_data=-12288; a=-1, b=1 -> resp_data=-1 (floor); a=24576, b=24576 (6.0*6.0) -> resp_data=131071, resp_sat=1.
REQ-029 All 4 requesters valid continuously -> grants in order 0,1,2,3,0,...; results carry ids 0,1,2,3 back-to-back, one per cycle.
REQ-030 resp_ready=0 for 5 cycles with the pipeline full -> req_ready all-zero, resp_* held stable; after release, both pending results emerge in order with no loss.
REQ-031 rst asserted for one cycle with two operations in flight -> no response appears afterwards; the first post-reset grant goes to requester 0 when all requesters are valid.
REQ-032 Only requester 2 valid after last_grant=3 -> requester 2 granted immediately; requesters 0 and 1 idle causes no bubble.

Source files
------------

// File: rtl/real_mul_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | real_mul_arbiter_pkg                                                     |
// | Shared helpers: fixed-point shift computation and saturation limits.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package real_mul_arbiter_pkg;

    function automatic int calc_shift(input int a_exp, input int b_exp, input int out_exp);
        return out_exp - a_exp - b_exp;
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) <<< (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) <<< (width - 1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/real_mul_arbiter_rr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arbiter                                                               |
// | Round-robin grant: search starts one past the last granted requester.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             en,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic w_found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            int w_cand;
            w_cand = (int'(last_grant) + k) % N_REQ;
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                grant_idx = IDX_W'(w_cand);
            end
        end
        if (en && w_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/real_mul_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | real_mul_arbiter                                                         |
// | N requesters share one signed fixed-point multiplier, 2-stage pipeline.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module real_mul_arbiter
    import real_mul_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 18,
    parameter int A_EXP   = -12,
    parameter int B_EXP   = -12,
    parameter int OUT_EXP = -12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req_valid,
    output logic [N_REQ-1:0]               req_ready,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0]    req_b,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [$clog2(N_REQ)-1:0]       resp_id,
    output logic [WIDTH-1:0]               resp_data,
    output logic                           resp_sat
);

    localparam int                        c_idx_w     = $clog2(N_REQ);
    localparam int                        c_shift     = calc_shift(A_EXP, B_EXP, OUT_EXP);
    localparam int                        c_prod_w    = 2 * WIDTH;
    localparam logic signed [c_prod_w-1:0] c_sat_max  = c_prod_w'(sat_max(WIDTH));
    localparam logic signed [c_prod_w-1:0] c_sat_min  = c_prod_w'(sat_min(WIDTH));
    localparam logic [WIDTH-1:0]          c_out_max   = c_sat_max[WIDTH-1:0];
    localparam logic [WIDTH-1:0]          c_out_min   = c_sat_min[WIDTH-1:0];
    localparam logic [c_idx_w-1:0]        c_last_init = c_idx_w'(N_REQ - 1);

    if (c_shift < 0 || N_REQ < 2) begin : g_cfg_error
        $fatal(1, "real_mul_arbiter: negative product shift or fewer than 2 requesters");
    end

    logic                        w_en;
    logic [N_REQ-1:0]            w_grant;
    logic [c_idx_w-1:0]          w_grant_idx;
    logic [c_idx_w-1:0]          r_last_grant;
    logic                        r_s1_valid;
    logic signed [WIDTH-1:0]     r_s1_a;
    logic signed [WIDTH-1:0]     r_s1_b;
    logic [c_idx_w-1:0]          r_s1_id;
    logic signed [c_prod_w-1:0]  w_prod;
    logic signed [c_prod_w-1:0]  w_shifted;
    logic                        w_over;
    logic                        w_under;
    logic [WIDTH-1:0]            w_sat_data;

    // Whole pipeline advances together; a stalled output freezes both stages.
    assign w_en      = !resp_valid || resp_ready;
    assign req_ready = w_grant;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_idx_w)
    ) u_rr (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .en         (w_en && !rst),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= c_last_init;
            r_s1_valid   <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= |w_grant;
            if (|w_grant) begin
                r_last_grant <= w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_en && |w_grant) begin
            r_s1_a  <= $signed(req_a[w_grant_idx]);
            r_s1_b  <= $signed(req_b[w_grant_idx]);
            r_s1_id <= w_grant_idx;
        end
    end

    // Arithmetic right shift gives floor rounding of the rescaled product.
    assign w_prod     = c_prod_w'(r_s1_a) * c_prod_w'(r_s1_b);
    assign w_shifted  = w_prod >>> c_shift;
    assign w_over     = w_shifted > c_sat_max;
    assign w_under    = w_shifted < c_sat_min;
    assign w_sat_data = w_over  ? c_out_max :
                        w_under ? c_out_min : w_shifted[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_sat   <= 1'b0;
        end else if (w_en) begin
            resp_valid <= r_s1_valid;
            if (r_s1_valid) begin
                resp_data <= w_sat_data;
                resp_id   <= r_s1_id;
                resp_sat  <= w_over || w_under;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_real_mul_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_real_mul_arbiter                                                      |
// | Scoreboard bench with a high-level arithmetic and arbitration model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_real_mul_arbiter;

    localparam int N  = 4;
    localparam int W  = 18;
    localparam int IW = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N-1:0][W-1:0] req_a;
    logic [N-1:0][W-1:0] req_b;
    logic                resp_valid;
    logic                resp_ready;
    logic [IW-1:0]       resp_id;
    logic [W-1:0]        resp_data;
    logic                resp_sat;

    always #5 clk = ~clk;

    real_mul_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .A_EXP   (-12),
        .B_EXP   (-12),
        .OUT_EXP (-12)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_sat   (resp_sat)
    );

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic          sat;
    } resp_t;

    resp_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    m_last;
    bit    m_s1_v;
    bit    m_resp_v;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Real-valued product floor(a*b / 4096), clamped to the signed 18-bit range.
    function automatic resp_t model(input int id, input logic signed [W-1:0] a,
                                    input logic signed [W-1:0] b);
        longint p, q;
        resp_t  r;
        p = longint'(a) * longint'(b);
        q = p / 4096;
        if ((p % 4096) != 0 && p < 0) q = q - 1;
        r.sat = (q > 131071) || (q < -131072);
        if (q > 131071)  q = 131071;
        if (q < -131072) q = -131072;
        r.data = W'(q);
        r.id   = IW'(id);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        int mode;
        mode = $urandom_range(0, 3);
        case (mode)
            0:       return W'($urandom);
            1:       return ($urandom_range(0, 1) == 0) ? W'(131071) : W'(-131072);
            default: return W'(int'($urandom_range(0, 16384)) - 8192);
        endcase
    endfunction

    task automatic rand_all_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i] = rand_op();
            req_b[i] = rand_op();
        end
    endtask

    // Called just after inputs are set on a falling edge; returns on the next one.
    task automatic cycle();
        logic [N-1:0] g;
        int           gi;
        bit           en;
        #1;
        g  = '0;
        gi = -1;
        en = !m_resp_v || resp_ready;
        if (rst) begin
            check("ready_in_reset", req_ready, 0);
            m_last   = N - 1;
            m_s1_v   = 1'b0;
            m_resp_v = 1'b0;
            exp_q.delete();
        end else begin
            check("resp_valid", resp_valid, m_resp_v);
            if (en) begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (m_last + k) % N;
                    if (gi < 0 && req_valid[c]) gi = c;
                end
            end
            if (gi >= 0) g[gi] = 1'b1;
            check("req_ready", req_ready, g);
            if (gi >= 0) begin
                exp_q.push_back(model(gi, req_a[gi], req_b[gi]));
                m_last = gi;
            end
            if (en) begin
                m_resp_v = m_s1_v;
                m_s1_v   = (gi >= 0);
            end
        end
        @(negedge clk);
    endtask

    task automatic single(input int id, input int a, input int b, input int ed, input int es);
        req_a[id]  = W'(a);
        req_b[id]  = W'(b);
        req_valid  = N'(1) << id;
        resp_ready = 1'b1;
        cycle();
        req_valid = '0;
        cycle();
        check("lat_valid", resp_valid, 1);
        check("lat_data", longint'($signed(resp_data)), ed);
        check("lat_id", resp_id, id);
        check("lat_sat", resp_sat, es);
        cycle();
    endtask

    // Monitor: pops the scoreboard on each output transfer and watches stalls.
    initial begin
        resp_t cur, hold, e;
        bit    holding;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            cur = '{id: resp_id, data: resp_data, sat: resp_sat};
            if (rst) begin
                holding = 1'b0;
            end else begin
                if (holding) check("stall_hold", cur, hold);
                if (resp_valid && resp_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_id", resp_id, e.id);
                        check("resp_data", longint'($signed(resp_data)), longint'($signed(e.data)));
                        check("resp_sat", resp_sat, e.sat);
                    end
                    holding = 1'b0;
                end else if (resp_valid) begin
                    hold    = cur;
                    holding = 1'b1;
                end else begin
                    holding = 1'b0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        req_a      = '0;
        req_b      = '0;
        m_last     = N - 1;
        m_s1_v     = 1'b0;
        m_resp_v   = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_sat", resp_sat, 0);

        single(0, 6144, 8192, 12288, 0);
        single(0, -6144, 8192, -12288, 0);
        single(0, -1, 1, -1, 0);
        single(0, 24576, 24576, 131071, 1);
        single(1, -24576, 24576, -131072, 1);

        // Two operations in flight, then a one-cycle reset discards them.
        req_valid = '1;
        rand_all_ops();
        cycle();
        rand_all_ops();
        cycle();
        rst = 1'b1;
        cycle();
        rst       = 1'b0;
        req_valid = '0;
        repeat (3) cycle();

        // All requesters valid: grants rotate 0,1,2,3 with one result per cycle.
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            rand_all_ops();
            cycle();
        end

        // Output stall with a full pipeline, then release and drain.
        resp_ready = 1'b0;
        repeat (5) cycle();
        resp_ready = 1'b1;
        req_valid  = '0;
        repeat (4) cycle();

        // After last grant 3, only requester 2 asks: it is served every cycle.
        req_valid = 4'b0100;
        repeat (4) begin
            rand_all_ops();
            cycle();
        end

        for (int i = 0; i < 400; i++) begin
            req_valid  = N'($urandom);
            resp_ready = ($urandom_range(0, 9) < 7);
            rand_all_ops();
            cycle();
        end

        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (6) cycle();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
